commit_trace_fifo: RTL and testbench

Buffers the core's per-cycle register-writeback commit trace (PC, destination register, write data) and presents it to the host/difftest side over a valid/ready stream. Sits directly downstream of the core top's debug trace port, decoupling the single-cycle commit pulses from a consumer that may stall. Every commit gets a 32-bit sequence number. Overflow drops the entry but never stalls the core, and it is recorded so the consumer can detect gaps.

---
 rtl/commit_trace_fifo.sv | 161 ++++++++++++++++
 tb/tb_commit_trace_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//
// Buffers the core's per-cycle register-writeback commit trace and hands it
// to a host/difftest consumer over a valid/ready stream. Every commit is
// tagged with a running sequence number. The core is never stalled. When the
// buffer is full and nothing drains in the same cycle, the commit is
// discarded. The loss is recorded in a sticky overflow flag and a saturating
// drop counter. The sequence number still advances, so the consumer can see
// the gap in out_seq.
//
// Ports
//   clock          sole clock, all state updates on the rising edge
//   reset          synchronous, active-high
//   debug_commit   commit strobe from the core, one commit per asserted cycle
//   debug_pc       committed instruction PC
//   debug_reg_num  destination register number
//   debug_wdata    value written to the destination register
//   out_valid      head entry available (level != 0)
//   out_ready      consumer takes the head when out_valid && out_ready
//   out_pc         head entry PC
//   out_reg_num    head entry register number
//   out_wdata      head entry write data
//   out_seq        head entry sequence number
//   level          current occupancy, 0..DEPTH
//   overflow       sticky, set by the first dropped commit
//   drop_count     dropped commits, saturating at 16'hFFFF
//   clear_overflow clears overflow and drop_count (a same-cycle drop wins)

module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     debug_commit,
  input  logic [63:0]              debug_pc,
  input  logic [4:0]               debug_reg_num,
  input  logic [63:0]              debug_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [4:0]               out_reg_num,
  output logic [63:0]              out_wdata,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Storage is split per field so each array has a single clean width.
  logic [63:0]      r_pcMem    [DEPTH];
  logic [4:0]       r_regMem   [DEPTH];
  logic [63:0]      r_wdataMem [DEPTH];
  logic [SEQ_W-1:0] r_seqMem   [DEPTH];

  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [LVL_W-1:0] r_level;
  logic [SEQ_W-1:0] r_seqNext;
  logic             r_overflow;
  logic [15:0]      r_dropCount;

  logic w_notEmpty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake decode. A pop frees a slot in the same cycle, so a commit into
  // a full buffer is still accepted when the consumer drains at the same time.
  always_comb begin
    w_notEmpty = (r_level != '0);
    w_full     = (r_level == FULL_LEVEL);
    w_pop      = w_notEmpty && out_ready;
    w_push     = debug_commit && (!w_full || w_pop);
    w_drop     = debug_commit && w_full && !w_pop;
  end

  // Pointer and occupancy bookkeeping. Pointers are exactly PTR_W bits wide,
  // so the power-of-two depth makes them wrap for free.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  // Entry storage is deliberately not reset. Writes are blocked during reset
  // so the inputs of the reset cycle leave no trace.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_pcMem[r_wrPtr]    <= debug_pc;
      r_regMem[r_wrPtr]   <= debug_reg_num;
      r_wdataMem[r_wrPtr] <= debug_wdata;
      r_seqMem[r_wrPtr]   <= r_seqNext;
    end
  end

  // The sequence counter counts every commit, stored or dropped. Dropped
  // commits therefore show up as holes in the consumer's sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seqNext <= '0;
    end else if (debug_commit) begin
      r_seqNext <= r_seqNext + SEQ_W'(1);
    end
  end

  // Overflow tracking. A drop in the same cycle as clear_overflow takes
  // priority. The counter restarts at one instead of being cleared, so that
  // drop is not lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_overflow) begin
        r_dropCount <= 16'd1;
      end else if (r_dropCount != DROP_MAX) begin
        r_dropCount <= r_dropCount + 16'd1;
      end
    end else if (clear_overflow) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end
  end

  // First-word-fall-through read side. The head entry is always presented
  // directly from storage at rd_ptr. There is no bypass from the write port.
  always_comb begin
    out_valid   = w_notEmpty;
    out_pc      = r_pcMem[r_rdPtr];
    out_reg_num = r_regMem[r_rdPtr];
    out_wdata   = r_wdataMem[r_rdPtr];
    out_seq     = r_seqMem[r_rdPtr];
    level       = r_level;
    overflow    = r_overflow;
    drop_count  = r_dropCount;
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo
//
// Randomised and directed bench for commit_trace_fifo. A queue-based model
// tracks what the buffer should hold. Each scenario task compares the DUT
// against that model or against fixed expected values.

module tb_commit_trace_fifo;

  localparam int DEPTH = 16;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rn;
    logic [63:0] wd;
    logic [31:0] seq;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        debug_commit = 1'b0;
  logic [63:0] debug_pc = '0;
  logic [4:0]  debug_reg_num = '0;
  logic [63:0] debug_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [4:0]  out_reg_num;
  logic [63:0] out_wdata;
  logic [31:0] out_seq;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clear_overflow = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state
  entry_t      modelQ[$];
  entry_t      dutRx[$];
  logic [31:0] mSeq = '0;
  logic        mOvf = 1'b0;
  logic [15:0] mDrop = '0;

  commit_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .debug_commit(debug_commit),
    .debug_pc(debug_pc),
    .debug_reg_num(debug_reg_num),
    .debug_wdata(debug_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_reg_num(out_reg_num),
    .out_wdata(out_wdata),
    .out_seq(out_seq),
    .level(level),
    .overflow(overflow),
    .drop_count(drop_count),
    .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  // Drive one cycle of stimulus and advance the model by the same cycle.
  // Any entry the DUT hands over is recorded from its own outputs.
  task automatic applyStimulus(input logic commit, input logic [63:0] pc,
                               input logic [4:0] rn, input logic [63:0] wd,
                               input logic ready, input logic clr,
                               input logic rst);
    entry_t e;
    bit     pop;
    bit     full;
    debug_commit   = commit;
    debug_pc       = pc;
    debug_reg_num  = rn;
    debug_wdata    = wd;
    out_ready      = ready;
    clear_overflow = clr;
    reset          = rst;
    if (!rst && out_valid && ready) begin
      e.pc = out_pc; e.rn = out_reg_num; e.wd = out_wdata; e.seq = out_seq;
      dutRx.push_back(e);
    end
    if (rst) begin
      modelQ.delete();
      mSeq  = '0;
      mOvf  = 1'b0;
      mDrop = '0;
    end else begin
      pop  = (modelQ.size() != 0) && ready;
      full = (modelQ.size() == DEPTH);
      if (pop) void'(modelQ.pop_front());
      if (commit && full && !pop) begin
        mOvf  = 1'b1;
        mDrop = clr ? 16'd1 : ((mDrop == 16'hFFFF) ? mDrop : mDrop + 16'd1);
      end else begin
        if (commit) begin
          e.pc = pc; e.rn = rn; e.wd = wd; e.seq = mSeq;
          modelQ.push_back(e);
        end
        if (clr) begin
          mOvf  = 1'b0;
          mDrop = '0;
        end
      end
      if (commit) mSeq = mSeq + 32'd1;
    end
    @(posedge clock);
    #1;
    debug_commit   = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    dutRx.delete();
  endtask

  // Push n commits with random payload and the given ready level.
  task automatic pushMany(input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, {$urandom, $urandom}, 5'($urandom),
                    {$urandom, $urandom}, ready, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    doReset();
    testsRun++;
    if ({out_valid, level, overflow, drop_count} !== {1'b0, 5'd0, 1'b0, 16'd0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got valid=%0b level=%0d ovf=%0b drops=%0d, required 0 0 0 0",
               out_valid, level, overflow, drop_count);
    end
  endtask

  task automatic test_single_commit();
    doReset();
    applyStimulus(1'b1, 64'h8000_0000, 5'd5, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    testsRun++;
    if ({out_valid, out_pc, out_reg_num, out_wdata, out_seq, level} !==
        {1'b1, 64'h8000_0000, 5'd5, 64'hDEAD, 32'd0, 5'd1}) begin
      testsFailed++;
      $display("[TB] FAIL single_head: got v=%0b pc=%h rn=%0d wd=%h seq=%0d lvl=%0d, required 1 80000000 5 dead 0 1",
               out_valid, out_pc, out_reg_num, out_wdata, out_seq, level);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if ({out_valid, level} !== {1'b0, 5'd0}) begin
      testsFailed++;
      $display("[TB] FAIL single_pop: got v=%0b lvl=%0d, required 0 0", out_valid, level);
    end
  endtask

  task automatic test_fill_wrap();
    logic [63:0] sentPc[40];
    logic [63:0] sentWd[40];
    doReset();
    for (int i = 0; i < 40; i++) begin
      sentPc[i] = {$urandom, $urandom};
      sentWd[i] = {$urandom, $urandom};
      applyStimulus(1'b1, sentPc[i], 5'(i), sentWd[i], 1'b1, 1'b0, 1'b0);
      testsRun++;
      if (level > 5'd1 || out_valid !== 1'b1 || out_seq !== 32'(i)) begin
        testsFailed++;
        $display("[TB] FAIL wrap_cycle%0d: got lvl=%0d v=%0b seq=%0d, required lvl<=1 v=1 seq=%0d",
                 i, level, out_valid, out_seq, i);
      end
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (dutRx.size() != 40 || overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count: got %0d entries ovf=%0b, required 40 ovf=0",
               dutRx.size(), overflow);
    end
    for (int i = 0; i < 40 && i < dutRx.size(); i++) begin
      testsRun++;
      if (dutRx[i].seq !== 32'(i) || dutRx[i].pc !== sentPc[i] || dutRx[i].wd !== sentWd[i]) begin
        testsFailed++;
        $display("[TB] FAIL wrap_entry%0d: got seq=%0d pc=%h wd=%h, required seq=%0d pc=%h wd=%h",
                 i, dutRx[i].seq, dutRx[i].pc, dutRx[i].wd, i, sentPc[i], sentWd[i]);
      end
    end
  endtask

  task automatic test_overflow();
    doReset();
    pushMany(18, 1'b0);
    testsRun++;
    if ({level, overflow, drop_count} !== {5'd16, 1'b1, 16'd2}) begin
      testsFailed++;
      $display("[TB] FAIL overflow_state: got lvl=%0d ovf=%0b drops=%0d, required 16 1 2",
               level, overflow, drop_count);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (dutRx.size() != 16 || level !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL overflow_drain: got %0d entries lvl=%0d, required 16 0", dutRx.size(), level);
    end
    for (int i = 0; i < dutRx.size() && i < 16; i++) begin
      testsRun++;
      if (dutRx[i].seq !== 32'(i)) begin
        testsFailed++;
        $display("[TB] FAIL overflow_seq%0d: got %0d, required %0d", i, dutRx[i].seq, i);
      end
    end
    pushMany(1, 1'b0);
    testsRun++;
    if ({out_valid, out_seq} !== {1'b1, 32'd18}) begin
      testsFailed++;
      $display("[TB] FAIL overflow_gap: got v=%0b seq=%0d, required 1 18", out_valid, out_seq);
    end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] lastPc;
    doReset();
    pushMany(16, 1'b0);
    lastPc = {$urandom, $urandom};
    applyStimulus(1'b1, lastPc, 5'd31, 64'h1234, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if ({level, overflow, drop_count} !== {5'd16, 1'b0, 16'd0}) begin
      testsFailed++;
      $display("[TB] FAIL full_pushpop: got lvl=%0d ovf=%0b drops=%0d, required 16 0 0",
               level, overflow, drop_count);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (dutRx.size() != 17 || dutRx[dutRx.size()-1].seq !== 32'd16 ||
        dutRx[dutRx.size()-1].pc !== lastPc) begin
      testsFailed++;
      $display("[TB] FAIL full_last: got %0d entries last seq=%0d pc=%h, required 17 16 %h",
               dutRx.size(), dutRx[dutRx.size()-1].seq, dutRx[dutRx.size()-1].pc, lastPc);
    end
  endtask

  task automatic test_clear_vs_drop();
    doReset();
    pushMany(19, 1'b0);
    testsRun++;
    if ({overflow, drop_count} !== {1'b1, 16'd3}) begin
      testsFailed++;
      $display("[TB] FAIL clear_setup: got ovf=%0b drops=%0d, required 1 3", overflow, drop_count);
    end
    applyStimulus(1'b1, '1, 5'd1, '1, 1'b0, 1'b1, 1'b0);
    testsRun++;
    if ({overflow, drop_count} !== {1'b1, 16'd1}) begin
      testsFailed++;
      $display("[TB] FAIL clear_with_drop: got ovf=%0b drops=%0d, required 1 1", overflow, drop_count);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    testsRun++;
    if ({overflow, drop_count, level} !== {1'b0, 16'd0, 5'd16}) begin
      testsFailed++;
      $display("[TB] FAIL clear_alone: got ovf=%0b drops=%0d lvl=%0d, required 0 0 16",
               overflow, drop_count, level);
    end
  endtask

  task automatic test_reset_midstream();
    doReset();
    pushMany(5, 1'b0);
    applyStimulus(1'b1, '1, 5'd9, '1, 1'b1, 1'b0, 1'b1);
    testsRun++;
    if ({out_valid, level} !== {1'b0, 5'd0}) begin
      testsFailed++;
      $display("[TB] FAIL midreset_state: got v=%0b lvl=%0d, required 0 0", out_valid, level);
    end
    pushMany(1, 1'b0);
    testsRun++;
    if ({out_valid, out_seq, level} !== {1'b1, 32'd0, 5'd1}) begin
      testsFailed++;
      $display("[TB] FAIL midreset_seq: got v=%0b seq=%0d lvl=%0d, required 1 0 1",
               out_valid, out_seq, level);
    end
  endtask

  task automatic test_random();
    entry_t h;
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 6, {$urandom, $urandom}, 5'($urandom),
                    {$urandom, $urandom}, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 249) == 0);
      testsRun++;
      if ({out_valid, level, overflow, drop_count} !==
          {modelQ.size() != 0, 5'(modelQ.size()), mOvf, mDrop}) begin
        testsFailed++;
        $display("[TB] FAIL random_state%0d: got v=%0b lvl=%0d ovf=%0b drops=%0d, required v=%0b lvl=%0d ovf=%0b drops=%0d",
                 i, out_valid, level, overflow, drop_count,
                 modelQ.size() != 0, modelQ.size(), mOvf, mDrop);
      end
      if (modelQ.size() != 0) begin
        h = modelQ[0];
        testsRun++;
        if ({out_pc, out_reg_num, out_wdata, out_seq} !== {h.pc, h.rn, h.wd, h.seq}) begin
          testsFailed++;
          $display("[TB] FAIL random_head%0d: got pc=%h rn=%0d wd=%h seq=%0d, required pc=%h rn=%0d wd=%h seq=%0d",
                   i, out_pc, out_reg_num, out_wdata, out_seq, h.pc, h.rn, h.wd, h.seq);
        end
      end
    end
  endtask

  // Run the scenarios in sequence and print the summary.
  initial begin
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_single_commit();
    test_fill_wrap();
    test_overflow();
    test_full_push_pop();
    test_clear_vs_drop();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
